// File: rtl/secded_encoder.sv
// Streaming SECDED Hamming encoder with a 2-stage valid/ready pipeline and a
// running count of emitted codewords.
// Optional build macro SECDED_ENCODER_ERROR_INJECT_EN adds inject_en/inject_mask
// inputs that XOR a mask into the codeword as it enters the output stage.
// Codeword layout: bit 0 is overall even parity, check bit c_k sits at position
// 2^k, data bits fill the remaining positions in ascending order.
// BUS_WIDTH must be >= CODE_WIDTH; upper output bus bits are driven to zero.
// PARITY_BITS must satisfy 2^PARITY_BITS >= CODE_WIDTH.
module secded_encoder #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned PARITY_BITS = 6,
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned DEST_WIDTH  = 4,
    parameter int unsigned BUS_WIDTH   = 64,
    localparam int unsigned CODE_WIDTH = DATA_WIDTH + PARITY_BITS + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    // payload stream
    input  logic [DATA_WIDTH-1:0]  data_in_data,
    input  logic                   data_in_valid,
    output logic                   data_in_ready,
    input  logic [DEST_WIDTH-1:0]  data_in_dest,
    // codeword stream
    output logic [BUS_WIDTH-1:0]   data_out_data,
    output logic                   data_out_valid,
    input  logic                   data_out_ready,
    output logic [DEST_WIDTH-1:0]  data_out_dest,
`ifdef SECDED_ENCODER_ERROR_INJECT_EN
    input  logic                   inject_en,
    input  logic [CODE_WIDTH-1:0]  inject_mask,
`endif
    output logic [COUNT_WIDTH-1:0] encoded_count
);

    localparam int unsigned CW_IDX = $clog2(CODE_WIDTH);
    localparam int unsigned DW_IDX = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                   r_s1_valid;
    logic [DATA_WIDTH-1:0]  r_s1_data;
    logic [DEST_WIDTH-1:0]  r_s1_dest;
    logic                   r_s2_valid;
    logic [CODE_WIDTH-1:0]  r_s2_code;
    logic [DEST_WIDTH-1:0]  r_s2_dest;
    logic [COUNT_WIDTH-1:0] r_count;

    logic                   w_s2_en;
    logic [CODE_WIDTH-1:0]  w_inject;
    logic [CODE_WIDTH-1:0]  w_code;

    // Place data bits at non-power-of-two positions, then fold them into the
    // check bits and finish with overall parity over positions 1..CODE_WIDTH-1.
    function automatic logic [CODE_WIDTH-1:0] f_encode(input logic [DATA_WIDTH-1:0] d);
        logic [CODE_WIDTH-1:0] cw;
        int unsigned           di;
        cw = '0;
        di = 0;
        for (int unsigned p = 1; p < CODE_WIDTH; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[CW_IDX'(p)] = d[DW_IDX'(di)];
                di++;
            end
        end
        for (int unsigned k = 0; k < PARITY_BITS; k++) begin
            for (int unsigned p = 1; p < CODE_WIDTH; p++) begin
                if (((p & (p - 1)) != 0) && (((p >> k) & 1) != 0)) begin
                    cw[CW_IDX'(1 << k)] = cw[CW_IDX'(1 << k)] ^ cw[CW_IDX'(p)];
                end
            end
        end
        cw[0] = ^cw[CODE_WIDTH-1:1];
        return cw;
    endfunction

    // S1 may take a new word unless both stages are full and the output stalls
    assign data_in_ready = !r_s1_valid || !r_s2_valid || data_out_ready;
    // S2 may load when empty or when its word drains this cycle
    assign w_s2_en       = !r_s2_valid || data_out_ready;

`ifdef SECDED_ENCODER_ERROR_INJECT_EN
    assign w_inject = inject_en ? inject_mask : '0;
`else
    assign w_inject = '0;
`endif

    // Codeword for the word currently held in S1, with optional corruption
    always_comb begin
        w_code = f_encode(r_s1_data) ^ w_inject;
    end

    // Stage 1: capture the incoming payload and dest
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_dest  <= '0;
        end else if (data_in_ready) begin
            r_s1_valid <= data_in_valid;
            if (data_in_valid) begin
                r_s1_data <= data_in_data;
                r_s1_dest <= data_in_dest;
            end
        end
    end

    // Stage 2: capture the codeword and dest; holds while stalled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_code  <= '0;
            r_s2_dest  <= '0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_code <= w_code;
                r_s2_dest <= r_s1_dest;
            end
        end
    end

    // Count completed output handshakes, wrapping naturally
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_s2_valid && data_out_ready) begin
            r_count <= r_count + COUNT_WIDTH'(1);
        end
    end

    assign data_out_valid = r_s2_valid;
    assign data_out_data  = BUS_WIDTH'(r_s2_code);
    assign data_out_dest  = r_s2_dest;
    assign encoded_count  = r_count;

endmodule

// File: tb/tb_secded_encoder.sv
// Self-checking bench for secded_encoder: table vectors, random back-to-back
// streaming under backpressure, reset while words are in flight, counter wrap
// (COUNT_WIDTH=4) and, when SECDED_ENCODER_ERROR_INJECT_EN is defined, injection.
module tb_secded_encoder;

    localparam int unsigned DW   = 32;
    localparam int unsigned DSTW = 4;
    localparam int unsigned BW   = 64;
    localparam int unsigned CNTW = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [DW-1:0]   data_in_data = '0;
    logic            data_in_valid = 1'b0;
    logic            data_in_ready;
    logic [DSTW-1:0] data_in_dest = '0;
    logic [BW-1:0]   data_out_data;
    logic            data_out_valid;
    logic            data_out_ready = 1'b1;
    logic [DSTW-1:0] data_out_dest;
    logic [CNTW-1:0] encoded_count;
`ifdef SECDED_ENCODER_ERROR_INJECT_EN
    logic            inject_en = 1'b0;
    logic [38:0]     inject_mask = '0;
`endif

    secded_encoder #(
        .DATA_WIDTH (DW),
        .PARITY_BITS(6),
        .COUNT_WIDTH(CNTW),
        .DEST_WIDTH (DSTW),
        .BUS_WIDTH  (BW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .data_in_data  (data_in_data),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .data_in_dest  (data_in_dest),
        .data_out_data (data_out_data),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .data_out_dest (data_out_dest),
`ifdef SECDED_ENCODER_ERROR_INJECT_EN
        .inject_en     (inject_en),
        .inject_mask   (inject_mask),
`endif
        .encoded_count (encoded_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0]   code;
        logic [DSTW-1:0] dest;
    } exp_t;

    typedef struct {
        logic [DW-1:0]   data;
        logic [DSTW-1:0] dest;
        logic [63:0]     code;
    } vec_t;

    int        checks = 0;
    int        errors = 0;
    exp_t      sb[$];
    exp_t      mon_e;
    int        occ = 0;
    logic [CNTW-1:0] exp_count = '0;
    logic      held_v = 1'b0;
    logic [63:0] held_data = '0;
    logic [DSTW-1:0] held_dest = '0;
    int        rdy_mode = 0;
    int        cyc = 0;
    vec_t      vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: accumulate the syndrome of the set data positions
    function automatic logic [63:0] model(input logic [DW-1:0] d);
        logic [63:0] cw;
        logic [5:0]  syn;
        int          idx;
        cw  = '0;
        syn = '0;
        idx = 0;
        for (int pos = 1; pos < 39; pos++) begin
            if ($countones(pos) != 1) begin
                if (d[5'(idx)]) begin
                    cw[6'(pos)] = 1'b1;
                    syn = syn ^ 6'(pos);
                end
                idx++;
            end
        end
        for (int k = 0; k < 6; k++) cw[6'(1 << k)] = syn[3'(k)];
        cw[0] = ^cw;
        return cw;
    endfunction

    // Output-ready pattern: 0 always high, 1 high one cycle in three, 2 low
    always @(posedge clock) begin
        #1;
        cyc++;
        case (rdy_mode)
            0:       data_out_ready = 1'b1;
            1:       data_out_ready = ((cyc % 3) == 0);
            default: data_out_ready = 1'b0;
        endcase
    end

    // Monitor: ready rule, counter, stall stability and scoreboard compare
    always @(negedge clock) begin
        if (!reset) begin
            chk("in_ready", 64'(data_in_ready), 64'((occ < 2) || data_out_ready));
            chk("count", 64'(encoded_count), 64'(exp_count));
            if (held_v) begin
                chk("stall_valid", 64'(data_out_valid), 64'd1);
                chk("stall_data", data_out_data, held_data);
                chk("stall_dest", 64'(data_out_dest), 64'(held_dest));
            end
            held_v    = data_out_valid && !data_out_ready;
            held_data = data_out_data;
            held_dest = data_out_dest;
            if (data_out_valid && data_out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got 0x%0h expected none", data_out_data);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_data", data_out_data, mon_e.code);
                    chk("out_dest", 64'(data_out_dest), 64'(mon_e.dest));
                end
                exp_count = exp_count + 1'b1;
                occ--;
            end
            if (data_in_valid && data_in_ready) occ++;
        end
    end

    // Present one word until accepted; records the expected codeword
    task automatic send(input logic [DW-1:0] d, input logic [DSTW-1:0] dst, input logic [63:0] code);
        int   n;
        logic hs;
        exp_t e;
        n  = 0;
        hs = 1'b0;
        data_in_valid = 1'b1;
        data_in_data  = d;
        data_in_dest  = dst;
        while (!hs && n < 200) begin
            @(negedge clock);
            hs = data_in_ready;
            if (hs) begin
                e.code = code;
                e.dest = dst;
                sb.push_back(e);
            end
            @(posedge clock);
            #1;
            n++;
        end
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready=0 expected ready=1 within 200 cycles");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        data_in_valid = 1'b0;
        while ((sb.size() != 0 || data_out_valid) && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        occ       = 0;
        exp_count = '0;
        held_v    = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] r;

        vecs[0] = '{32'h0000_0000, 4'h1, 64'h00_0000_0000};
        vecs[1] = '{32'h0000_0001, 4'h5, 64'h00_0000_000F};
        vecs[2] = '{32'h0000_0002, 4'h2, 64'h00_0000_0033};
        vecs[3] = '{32'h0000_0004, 4'h3, 64'h00_0000_0055};
        vecs[4] = '{32'h0000_0008, 4'h4, 64'h00_0000_0096};
        vecs[5] = '{32'h0000_0003, 4'h6, 64'h00_0000_003C};
        vecs[6] = '{32'h0000_0010, 4'h7, 64'h00_0000_0303};
        vecs[7] = '{32'h8000_0000, 4'hF, 64'h41_0000_0014};

        rdy_mode = 0;
        repeat (2) @(posedge clock);
        #1;
        do_reset();
        chk("rst_valid", 64'(data_out_valid), 64'd0);
        chk("rst_data", data_out_data, 64'd0);
        chk("rst_dest", 64'(data_out_dest), 64'd0);
        chk("rst_count", 64'(encoded_count), 64'd0);
        chk("rst_in_ready", 64'(data_in_ready), 64'd1);

        // First word: two-cycle latency with no backpressure
        send(32'h0, 4'h3, 64'h0);
        data_in_valid = 1'b0;
        chk("lat_cycle1_valid", 64'(data_out_valid), 64'd0);
        @(posedge clock);
        #1;
        chk("lat_cycle2_valid", 64'(data_out_valid), 64'd1);
        chk("lat_cycle2_data", data_out_data, 64'h0);
        drain();
        chk("count_first", 64'(encoded_count), 64'd1);

        // Table vectors, back to back
        for (int i = 0; i < 8; i++) send(vecs[i].data, vecs[i].dest, vecs[i].code);
        drain();

        // Eight random words under 1,0,0 output backpressure
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            r = $urandom();
            send(r, 4'(i), model(r));
        end
        drain();
        rdy_mode = 0;
        @(posedge clock);
        #1;

        // Reset with two words in flight
        rdy_mode = 2;
        @(posedge clock);
        #1;
        send(32'hDEAD_BEEF, 4'hA, model(32'hDEAD_BEEF));
        send(32'h1234_5678, 4'hB, model(32'h1234_5678));
        data_in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_valid", 64'(data_out_valid), 64'd0);
        chk("midrst_data", data_out_data, 64'd0);
        chk("midrst_count", 64'(encoded_count), 64'd0);
        rdy_mode = 0;
        do_reset();
        send(32'hCAFE_0001, 4'h9, model(32'hCAFE_0001));
        data_in_valid = 1'b0;
        chk("postrst_cycle1_valid", 64'(data_out_valid), 64'd0);
        @(posedge clock);
        #1;
        chk("postrst_cycle2_valid", 64'(data_out_valid), 64'd1);
        chk("postrst_cycle2_data", data_out_data, model(32'hCAFE_0001));
        drain();

        // Counter wrap: 17 words into a 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) begin
            r = $urandom();
            send(r, 4'(i), model(r));
        end
        drain();
        chk("count_wrap", 64'(encoded_count), 64'd1);

`ifdef SECDED_ENCODER_ERROR_INJECT_EN
        // Inject on the cycle the word moves into S2; next word is clean
        inject_mask = 39'h20;
        send(32'h1, 4'h2, 64'h2F);
        data_in_valid = 1'b0;
        inject_en = 1'b1;
        @(posedge clock);
        #1;
        inject_en = 1'b0;
        send(32'h1, 4'h3, 64'h0F);
        drain();
        chk("inject_count", 64'(encoded_count), 64'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/secded_encoder.md
Name: secded_encoder

Overview:
- Streaming SECDED Hamming encoder: DATA_WIDTH-bit words in, (DATA_WIDTH+PARITY_BITS+1)-bit codewords out.
- Transmit-side counterpart of the stream decoder / syndrome calculator chain; codeword layout matches what the decoder expects.
- Sits between a producer stream and a storage or link path.
- 2-stage valid/ready pipeline, full throughput, keeps a running count of emitted codewords.

Parameters:
- DATA_WIDTH, 32, payload bits per word.
- PARITY_BITS, 6, Hamming check bits; must satisfy 2^PARITY_BITS >= DATA_WIDTH+PARITY_BITS+1.
- CODE_WIDTH, DATA_WIDTH+PARITY_BITS+1 (39), codeword width; derived localparam, not overridable.
- COUNT_WIDTH, 32, width of the codeword counter.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  axi_stream.slave  iface  payload stream; uses data[DATA_WIDTH-1:0], valid, ready, dest.
- data_out  axi_stream.master  iface  codeword stream; drives data[CODE_WIDTH-1:0] with upper bits 0, valid, dest; samples ready.
- encoded_count  output  COUNT_WIDTH  number of completed data_out handshakes since reset.

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset).
- Reset (asynchronous, takes effect immediately):
  - data_out.valid=0, data_out.data=0, data_out.dest=0.
  - encoded_count=0; both stage valids cleared; in-flight words discarded.
  - data_in.ready=1 in the first cycle after reset deasserts.
- Codeword layout, Hamming positions 1..CODE_WIDTH-1 map to codeword bit p:
  - Check bit c_k at position 2^k, k=0..PARITY_BITS-1.
  - Data bits fill the non-power-of-two positions in ascending order: data[0] at position 3, data[1] at 5, data[2] at 6, data[3] at 7, data[4] at 9, and so on.
  - c_k = XOR of all data-bearing positions p with bit k of p set.
  - codeword[0] = XOR of codeword[CODE_WIDTH-1:1] (overall even parity).
- Pipeline:
  - S1 registers the input word and dest.
  - S2 registers the codeword and dest and drives data_out.
  - Latency 2 cycles from input handshake to data_out.valid when there is no backpressure; throughput 1 word/cycle.
- Handshake rules:
  - Stage advance rule: a stage loads when it is empty or its contents move forward in the same cycle.
  - data_in.ready = !s1_valid | !s2_valid | data_out.ready.
  - data_out.valid, data and dest hold stable while valid && !ready; no word is dropped or duplicated.
  - Simultaneous input accept and output drain while full: both complete, occupancy unchanged.
- Counter:
  - encoded_count increments by 1 on each data_out.valid && data_out.ready.
  - Wraps modulo 2^COUNT_WIDTH with no saturation.

Optional Feature:
- Macro: SECDED_ENCODER_ERROR_INJECT_EN.
- When defined:
  - Extra inputs inject_en (1 bit) and inject_mask (CODE_WIDTH bits).
  - When inject_en=1 at the cycle a word is loaded into S2, that codeword is XORed with inject_mask. Used by the decoder bench.
  - encoded_count still counts corrupted words.
- When undefined: ports absent, codeword never modified.

Test Plan:
- Reset, send data 0x00000000 with data_out.ready=1 -> codeword 0x0000000000 two cycles later; encoded_count=1.
- Send 0x00000001 -> codeword 0x000000000F (bits 3,2,1 set, overall parity bit0=1); dest passes through unchanged.
- Stream 8 back-to-back words, data_out.ready toggling 1,0,0,1,... -> all 8 codewords out in order, none lost or duplicated, stable while stalled; data_in.ready falls only with both stages full and ready=0.
- Assert reset for 1 cycle with 2 words in flight -> data_out.valid=0 immediately; encoded_count=0; the next input word emerges correctly after 2 cycles.
- COUNT_WIDTH=4, send 17 words -> encoded_count reaches 15, wraps to 0, ends at 1.
- With SECDED_ENCODER_ERROR_INJECT_EN, inject_mask=0x20 and inject_en=1 on word 0x00000001 -> output 0x000000002F; the following word is uncorrupted.
